// File: rtl/sga_snake_core_if.sv
// Control/status bundle for sga_snake_core: step/direction requests in,
// head/size/flags and the registered segment read port out.
interface sga_snake_core_if #(
  parameter int unsigned GRID_BITS = 3,
  parameter int unsigned MAX_LEN   = 64
);
  localparam int unsigned CW = 2 * GRID_BITS;
  localparam int unsigned IW = $clog2(MAX_LEN);
  localparam int unsigned SW = $clog2(MAX_LEN + 1);

  logic          step;
  logic [1:0]    dir_in;
  logic          wrap_mode;
  logic [CW-1:0] apple;
  logic [IW-1:0] seg_idx;
  logic [CW-1:0] seg_pos;
  logic [CW-1:0] head;
  logic [SW-1:0] size;
  logic [1:0]    direction;
  logic          busy;
  logic          done;
  logic          ate;
  logic          wall_collision;
  logic          self_collision;
  logic          won;
  logic          lost;

  modport master (
    output step, dir_in, wrap_mode, apple, seg_idx,
    input  seg_pos, head, size, direction, busy, done, ate,
           wall_collision, self_collision, won, lost
  );

  modport slave (
    input  step, dir_in, wrap_mode, apple, seg_idx,
    output seg_pos, head, size, direction, busy, done, ate,
           wall_collision, self_collision, won, lost
  );
endinterface

// File: rtl/sga_snake_core.sv
// Snake game core: circular body buffer, move/eat/collision FSM.
// Define SGA_SELF_COLLISION_EN to build the serial self-collision SCAN state.
module sga_snake_core #(
  parameter int unsigned GRID_BITS = 3,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned INIT_LEN  = 3
) (
  input logic            clock,
  input logic            restart,
  sga_snake_core_if.slave bus
);
  localparam int unsigned PW = $clog2(MAX_LEN);
  localparam int unsigned SW = $clog2(MAX_LEN + 1);
  localparam int unsigned CW = 2 * GRID_BITS;
  localparam logic [GRID_BITS-1:0] EDGE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
`ifdef SGA_SELF_COLLISION_EN
    SCAN,
`endif
    COMMIT,
    OVER
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] body [MAX_LEN];
  logic [PW-1:0] head_ptr, tail_ptr;
  logic [CW-1:0] head_q, next_head, calc_head, seg_pos_q;
  logic [SW-1:0] size_q;
  logic [1:0]    dir_q, dir_eff;
  logic          eat_q, calc_wall, grow_win, done_next;
  logic          done_q, ate_q, wall_q, won_q, lost_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + PW'(1);
  endfunction

  // Buffer slot of segment i counted back from the head, modulo MAX_LEN.
  function automatic logic [PW-1:0] ptr_sub(input logic [PW-1:0] p, input logic [SW-1:0] i);
    int unsigned t;
    t = 32'(p) + MAX_LEN - 32'(i);
    if (t >= MAX_LEN) t = t - MAX_LEN;
    return PW'(t);
  endfunction

  always_comb begin
    logic [GRID_BITS-1:0] x, y;
    x = head_q[GRID_BITS-1:0];
    y = head_q[CW-1:GRID_BITS];
    // 00/11 and 01/10 are opposite pairs, so reversal is a bitwise inverse.
    dir_eff = ((bus.dir_in == ~dir_q) && (size_q > SW'(1))) ? dir_q : bus.dir_in;
    calc_wall = 1'b0;
    case (dir_eff)
      2'b00: begin calc_wall = (x == EDGE_MAX); x = x + GRID_BITS'(1); end
      2'b01: begin calc_wall = (y == EDGE_MAX); y = y + GRID_BITS'(1); end
      2'b10: begin calc_wall = (y == '0);       y = y - GRID_BITS'(1); end
      default: begin calc_wall = (x == '0);     x = x - GRID_BITS'(1); end
    endcase
    if (bus.wrap_mode) calc_wall = 1'b0;
    calc_head = {y, x};
  end

  assign grow_win = eat_q && (size_q == SW'(MAX_LEN - 1));

`ifdef SGA_SELF_COLLISION_EN
  logic [SW-1:0] scan_idx;
  logic          scan_last, scan_hit, self_q;

  // The tail slot is vacated by this move unless it eats, so it only blocks when growing.
  assign scan_last = (scan_idx == size_q - SW'(1));
  assign scan_hit  = (body[ptr_sub(head_ptr, scan_idx)] == next_head) && !(scan_last && !eat_q);
`endif

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: if (bus.step) state_next = CALC;
      CALC: begin
        if (calc_wall) begin
          state_next = OVER;
          done_next  = 1'b1;
        end else begin
`ifdef SGA_SELF_COLLISION_EN
          state_next = SCAN;
`else
          state_next = COMMIT;
`endif
        end
      end
`ifdef SGA_SELF_COLLISION_EN
      SCAN: begin
        if (scan_hit) begin
          state_next = OVER;
          done_next  = 1'b1;
        end else if (scan_last) begin
          state_next = COMMIT;
        end
      end
`endif
      COMMIT: begin
        done_next  = 1'b1;
        state_next = grow_win ? OVER : IDLE;
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      for (int unsigned k = 0; k < MAX_LEN; k++)
        body[PW'(k)] <= (k < INIT_LEN) ? CW'(k) : '0;
      head_ptr  <= PW'(INIT_LEN - 1);
      tail_ptr  <= '0;
      head_q    <= CW'(INIT_LEN - 1);
      next_head <= '0;
      size_q    <= SW'(INIT_LEN);
      dir_q     <= 2'b00;
      eat_q     <= 1'b0;
      seg_pos_q <= '0;
      done_q    <= 1'b0;
      ate_q     <= 1'b0;
      wall_q    <= 1'b0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
`ifdef SGA_SELF_COLLISION_EN
      scan_idx  <= '0;
      self_q    <= 1'b0;
`endif
    end else begin
      done_q    <= done_next;
      ate_q     <= 1'b0;
      seg_pos_q <= (SW'(bus.seg_idx) >= size_q) ? '0
                 : body[ptr_sub(head_ptr, SW'(bus.seg_idx))];
      case (state)
        CALC: begin
          dir_q     <= dir_eff;
          next_head <= calc_head;
          eat_q     <= (calc_head == bus.apple);
`ifdef SGA_SELF_COLLISION_EN
          scan_idx  <= '0;
`endif
          if (calc_wall) begin
            wall_q <= 1'b1;
            lost_q <= 1'b1;
          end
        end
`ifdef SGA_SELF_COLLISION_EN
        SCAN: begin
          scan_idx <= scan_idx + SW'(1);
          if (scan_hit) begin
            self_q <= 1'b1;
            lost_q <= 1'b1;
          end
        end
`endif
        COMMIT: begin
          head_ptr              <= ptr_inc(head_ptr);
          body[ptr_inc(head_ptr)] <= next_head;
          head_q                <= next_head;
          if (eat_q) begin
            size_q <= size_q + SW'(1);
            ate_q  <= 1'b1;
            if (grow_win) won_q <= 1'b1;
          end else begin
            tail_ptr <= ptr_inc(tail_ptr);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.seg_pos        = seg_pos_q;
  assign bus.head           = head_q;
  assign bus.size           = size_q;
  assign bus.direction      = dir_q;
  assign bus.busy           = (state != IDLE) && (state != OVER);
  assign bus.done           = done_q;
  assign bus.ate            = ate_q;
  assign bus.wall_collision = wall_q;
  assign bus.won            = won_q;
  assign bus.lost           = lost_q;
`ifdef SGA_SELF_COLLISION_EN
  assign bus.self_collision = self_q;
`else
  assign bus.self_collision = 1'b0;
`endif
endmodule

// File: tb/tb_sga_snake_core.sv
// Bench for sga_snake_core (GRID_BITS=3, MAX_LEN=64, INIT_LEN=3): step vectors
// from a table plus hand sequences for wall, wrap, render reads and restart.
module tb_sga_snake_core;
`ifdef SGA_SELF_COLLISION_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic restart;
  always #5 clock = ~clock;

  sga_snake_core_if #(.GRID_BITS(3), .MAX_LEN(64)) bus ();
  sga_snake_core #(.GRID_BITS(3), .MAX_LEN(64), .INIT_LEN(3)) dut (
    .clock(clock), .restart(restart), .bus(bus)
  );

  typedef struct {
    logic [5:0]  head;
    logic [6:0]  size;
    logic [1:0]  dir;
    logic        ate, wall, self_c, lost;
    int unsigned n;
  } exp_t;

  typedef struct {
    logic [1:0]  dir;
    logic [5:0]  apple;
    logic [5:0]  head;
    logic [6:0]  size;
    logic [1:0]  exp_dir;
    logic        ate, self_c;
    int unsigned n;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] head, input logic [6:0] size, input logic [1:0] dir,
                              input logic ate, input logic wall, input logic self_c, input logic lost,
                              input int unsigned n);
    exp_t e;
    e.head = head; e.size = size; e.dir = dir; e.ate = ate;
    e.wall = wall; e.self_c = self_c; e.lost = lost; e.n = n;
    return e;
  endfunction

  function automatic int unsigned full_n(input int unsigned size_before);
    return SCAN_ON ? 3 + size_before : 3;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    restart = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_head", bus.head, 6'h02);
    check("rst_size", bus.size, 7'd3);
    check("rst_dir", bus.direction, 2'b00);
    check("rst_seg_pos", bus.seg_pos, 6'h00);
    check("rst_flags", {bus.busy, bus.done, bus.ate, bus.wall_collision,
                        bus.self_collision, bus.won, bus.lost}, 7'b0);
    @(negedge clock);
    restart = 1'b0;
  endtask

  // Drives one step, queues its expectation, then waits (bounded) for done and scores it.
  task automatic do_step(input logic [1:0] dir, input logic wrap, input logic [5:0] apple, input exp_t e);
    exp_t        x;
    int unsigned edges;
    bit          seen;
    @(negedge clock);
    bus.step = 1'b1; bus.dir_in = dir; bus.wrap_mode = wrap; bus.apple = apple;
    sb.push_back(e);
    @(posedge clock);
    edges = 1;
    #1 bus.step = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (bus.done) seen = 1'b1;
      else begin
        @(posedge clock);
        edges++;
      end
    end
    x = sb.pop_front();
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", edges, x.n);
    check("head", bus.head, x.head);
    check("size", bus.size, x.size);
    check("direction", bus.direction, x.dir);
    check("ate", bus.ate, x.ate);
    check("wall_collision", bus.wall_collision, x.wall);
    check("self_collision", bus.self_collision, x.self_c);
    check("lost", bus.lost, x.lost);
    @(negedge clock);
    check("done_one_cycle", bus.done, 1'b0);
  endtask

  task automatic read_seg(input logic [5:0] idx, input logic [5:0] exp, input string name);
    @(negedge clock);
    bus.seg_idx = idx;
    @(posedge clock);
    #1 check(name, bus.seg_pos, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_seen;
    restart = 1'b1;
    bus.step = 1'b0; bus.dir_in = 2'b00; bus.wrap_mode = 1'b1;
    bus.apple = 6'h3F; bus.seg_idx = '0;

    // Body after each step is listed head-first in the trailing comment.
    vecs[0] = '{2'b00, 6'h3F, 6'h03, 7'd3, 2'b00, 1'b0, 1'b0, full_n(3)}; // 03 02 01
    vecs[1] = '{2'b00, 6'h04, 6'h04, 7'd4, 2'b00, 1'b1, 1'b0, full_n(3)}; // 04 03 02 01
    vecs[2] = '{2'b11, 6'h3F, 6'h05, 7'd4, 2'b00, 1'b0, 1'b0, full_n(4)}; // reversal ignored
    vecs[3] = '{2'b00, 6'h06, 6'h06, 7'd5, 2'b00, 1'b1, 1'b0, full_n(4)}; // 06 05 04 03 02
    vecs[4] = '{2'b01, 6'h3F, 6'h0E, 7'd5, 2'b01, 1'b0, 1'b0, full_n(5)}; // 0E 06 05 04 03
    vecs[5] = '{2'b11, 6'h3F, 6'h0D, 7'd5, 2'b11, 1'b0, 1'b0, full_n(5)}; // 0D 0E 06 05 04
`ifdef SGA_SELF_COLLISION_EN
    vecs[6] = '{2'b10, 6'h3F, 6'h0D, 7'd5, 2'b10, 1'b0, 1'b1, 6};         // hits segment 3 (05)
`else
    vecs[6] = '{2'b10, 6'h3F, 6'h05, 7'd5, 2'b10, 1'b0, 1'b0, 3};
`endif

    do_reset();

    do_step(2'b00, 1'b1, 6'h03, mk(6'h03, 7'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, full_n(3)));
    read_seg(6'd3, 6'h00, "seg3_after_eat");
    read_seg(6'd4, 6'h00, "seg_beyond_size");
    read_seg(6'd0, 6'h03, "seg0_head");
    read_seg(6'd1, 6'h02, "seg1");

    // Restart asserted between clock edges while the step is in flight.
    do_reset();
    @(negedge clock);
    bus.step = 1'b1; bus.dir_in = 2'b00; bus.apple = 6'h3F; bus.wrap_mode = 1'b1;
    @(posedge clock);
    #1 bus.step = 1'b0;
    repeat (2) @(posedge clock);
    #2 restart = 1'b1;
    #1;
    check("midscan_rst_busy", bus.busy, 1'b0);
    check("midscan_rst_head", bus.head, 6'h02);
    check("midscan_rst_size", bus.size, 7'd3);
    @(negedge clock);
    restart = 1'b0;

    do_reset();
    foreach (vecs[i])
      do_step(vecs[i].dir, 1'b1, vecs[i].apple,
              mk(vecs[i].head, vecs[i].size, vecs[i].exp_dir, vecs[i].ate, 1'b0,
                 vecs[i].self_c, vecs[i].self_c, vecs[i].n));

    // Wall hit at X=7, then OVER must ignore further steps.
    do_reset();
    for (int k = 3; k <= 7; k++)
      do_step(2'b00, 1'b0, 6'h3F, mk(6'(k), 7'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, full_n(3)));
    do_step(2'b00, 1'b0, 6'h3F, mk(6'h07, 7'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2));
    @(negedge clock);
    bus.step = 1'b1;
    @(posedge clock);
    #1 bus.step = 1'b0;
    done_seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      done_seen = done_seen | bus.done;
    end
    check("over_no_done", done_seen, 1'b0);
    check("over_busy", bus.busy, 1'b0);
    check("over_lost_held", bus.lost, 1'b1);
    check("over_wall_held", bus.wall_collision, 1'b1);
    check("over_head_held", bus.head, 6'h07);

    // Same path with wrapping: X=7 moving right lands on X=0.
    do_reset();
    for (int k = 3; k <= 7; k++)
      do_step(2'b00, 1'b1, 6'h3F, mk(6'(k), 7'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, full_n(3)));
    do_step(2'b00, 1'b1, 6'h3F, mk(6'h00, 7'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, full_n(3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
